// File: rtl/ysyx_24100005_dmem_responder_if.sv
// Data-port request/response bundle between the core's load/store unit (master)
// and the memory-side responder (slave).
interface ysyx_24100005_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_24100005_dmem_responder.sv
// Single-outstanding data memory responder with fixed response latency.
// Optional alignment fault detection: define YSYX_24100005_DMEM_ALIGN_CHECK_EN.
module ysyx_24100005_dmem_responder #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input logic                           clk,
    input logic                           rst,
    ysyx_24100005_dmem_responder_if.slave bus
);
    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [32:0] RANGE_BYTES = 33'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [3:0]              cnt_r;
    logic                    wen_r;
    logic [31:0]             addr_r;
    logic [31:0]             wdata_r;
    logic [3:0]              wmask_r;
    logic [31:0]             rdata_r;
    logic                    err_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [31:0]             mem_r [0:DEPTH-1];

    logic [31:0]             offset_s;
    logic                    in_range_s;
    logic [DEPTH_LOG2-1:0]   idx_s;
    logic                    misalign_s;
    logic                    fault_s;
    logic                    access_s;
    logic                    we_s;
    logic                    unused_wmask_s;

    assign bus.req_ready  = req_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_rdata  = rdata_r;
    assign bus.rsp_err    = err_r;
    assign unused_wmask_s = ^bus.req_wmask[7:4];

    assign offset_s   = addr_r - BASE;
    assign in_range_s = ({1'b0, offset_s} < RANGE_BYTES);
    assign idx_s      = offset_s[DEPTH_LOG2+1:2];
    assign fault_s    = !in_range_s || misalign_s;
    assign access_s   = (state_r == BUSY) && (cnt_r == 4'd0);
    // A reset on the commit edge must suppress the pending store.
    assign we_s       = access_s && wen_r && !fault_s && !rst;

    // Alignment fault decode for the latched request.
    always_comb begin
        misalign_s = 1'b0;
`ifdef YSYX_24100005_DMEM_ALIGN_CHECK_EN
        if (!wen_r || (wmask_r == 4'b1111)) begin
            misalign_s = (addr_r[1:0] != 2'b00);
        end else if ((wmask_r == 4'b0011) || (wmask_r == 4'b1100)) begin
            misalign_s = addr_r[0];
        end else begin
            misalign_s = 1'b0;
        end
`endif
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) state_nxt_s = BUSY;
                else               state_nxt_s = IDLE;
            end
            BUSY: begin
                if (cnt_r == 4'd0) state_nxt_s = RESP;
                else               state_nxt_s = BUSY;
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt_s = IDLE;
                else               state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Request latch, latency counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 4'd0;
            wen_r   <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            wmask_r <= 4'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        wen_r   <= bus.req_wen;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        wmask_r <= bus.req_wmask[3:0];
                        cnt_r   <= 4'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rdata_r <= (!wen_r && !fault_s) ? mem_r[idx_s] : 32'd0;
                        err_r   <= fault_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_s && wmask_r[i]) begin
                mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24100005_dmem_responder.sv
// Directed self-checking bench for the data memory responder (LATENCY 2 and 1 instances).
module tb_ysyx_24100005_dmem_responder;
    logic clk;
    logic rst;
    int   total_cnt;
    int   pass_cnt;

    ysyx_24100005_dmem_responder_if bus0 ();
    ysyx_24100005_dmem_responder_if bus1 ();

    ysyx_24100005_dmem_responder #(.LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ysyx_24100005_dmem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request on bus0 and hold it until the accepting edge.
    task automatic start_req(input logic wen, input logic [31:0] a, input logic [31:0] d,
                             input logic [7:0] m, output logic ready_after);
        int n;
        @(negedge clk);
        bus0.req_wen = wen; bus0.req_addr = a; bus0.req_wdata = d; bus0.req_wmask = m;
        bus0.req_valid = 1'b1;
        n = 0;
        while (!bus0.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        ready_after = bus0.req_ready;
    endtask

    // Count edges from the accept edge until rsp_valid is seen (called at first negedge after accept).
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus0.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_timeout", 32'(lat < 20), 32'd1);
    endtask

    task automatic finish_rsp();
        bus0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.rsp_ready = 1'b0;
    endtask

    task automatic access(input logic wen, input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] m, output logic [31:0] rd, output logic er,
                          output int lat, output logic ready_after);
        start_req(wen, a, d, m, ready_after);
        wait_rsp(lat);
        rd = bus0.rsp_rdata;
        er = bus0.rsp_err;
        finish_rsp();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rd_hold;
        logic        er;
        logic        rdy;
        int          lat;

        total_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = 32'd0;
        bus0.req_wdata = 32'd0; bus0.req_wmask = 8'd0; bus0.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_wen = 1'b0; bus1.req_addr = 32'd0;
        bus1.req_wdata = 32'd0; bus1.req_wmask = 8'd0; bus1.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rdata", bus0.rsp_rdata, 32'd0);
        check("rst_err", 32'(bus0.rsp_err), 32'd0);

        // 1: full-word store then load back
        access(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, rd, er, lat, rdy);
        check("st1_ready_fall", 32'(rdy), 32'd0);
        check("st1_latency", 32'(lat), 32'd2);
        check("st1_err", 32'(er), 32'd0);
        check("st1_rdata", rd, 32'd0);
        check("idle_ready", 32'(bus0.req_ready), 32'd1);
        access(1'b0, 32'h8000_0010, 32'd0, 8'h00, rd, er, lat, rdy);
        check("ld1_rdata", rd, 32'hDEAD_BEEF);
        check("ld1_err", 32'(er), 32'd0);

        // 2: byte-lane mask, then upper mask bits ignored
        access(1'b1, 32'h8000_0010, 32'h1122_3344, 8'h05, rd, er, lat, rdy);
        access(1'b0, 32'h8000_0010, 32'd0, 8'h00, rd, er, lat, rdy);
        check("ld2_rdata", rd, 32'hDE22_BE44);
        access(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, rd, er, lat, rdy);
        check("st2_err", 32'(er), 32'd0);
        access(1'b0, 32'h8000_0010, 32'd0, 8'h00, rd, er, lat, rdy);
        check("ld2b_rdata", rd, 32'hDE22_BE44);

        // 3: response backpressure with a competing request held
        start_req(1'b0, 32'h8000_0010, 32'd0, 8'h00, rdy);
        wait_rsp(lat);
        rd_hold = bus0.rsp_rdata;
        check("bp_first_rdata", rd_hold, 32'hDE22_BE44);
        bus0.req_wen = 1'b1; bus0.req_addr = 32'h8000_0010; bus0.req_wdata = 32'h0;
        bus0.req_wmask = 8'h00; bus0.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
            check("bp_rdata", bus0.rsp_rdata, 32'hDE22_BE44);
            check("bp_err", 32'(bus0.rsp_err), 32'd0);
            check("bp_req_ready", 32'(bus0.req_ready), 32'd0);
        end
        bus0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.rsp_ready = 1'b0;
        check("bp_after_hs_ready", 32'(bus0.req_ready), 32'd1);
        check("bp_after_hs_valid", 32'(bus0.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        check("bp_next_accepted", 32'(bus0.req_ready), 32'd0);
        wait_rsp(lat);
        check("bp_next_latency", 32'(lat), 32'd2);
        check("bp_next_err", 32'(bus0.rsp_err), 32'd0);
        finish_rsp();

        // 4: out-of-range accesses
        access(1'b1, 32'h8000_0000, 32'h1234_5678, 8'h0F, rd, er, lat, rdy);
        access(1'b0, 32'h7FFF_FFFC, 32'd0, 8'h00, rd, er, lat, rdy);
        check("oor_low_err", 32'(er), 32'd1);
        check("oor_low_rdata", rd, 32'd0);
        access(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, rd, er, lat, rdy);
        check("oor_high_err", 32'(er), 32'd1);
        access(1'b0, 32'h8000_0000, 32'd0, 8'h00, rd, er, lat, rdy);
        check("word0_unchanged", rd, 32'h1234_5678);
        access(1'b0, 32'h8000_0FFC, 32'd0, 8'h00, rd, er, lat, rdy);
        check("last_word_err", 32'(er), 32'd0);

        // 5: reset while BUSY drops the store
        access(1'b1, 32'h8000_0020, 32'h0000_0000, 8'h0F, rd, er, lat, rdy);
        start_req(1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 8'h0F, rdy);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_busy_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("rst_busy_ready", 32'(bus0.req_ready), 32'd1);
        access(1'b0, 32'h8000_0020, 32'd0, 8'h00, rd, er, lat, rdy);
        check("rst_busy_no_write", rd, 32'd0);

        // 5b: LATENCY=1 instance
        @(negedge clk);
        bus1.req_wen = 1'b1; bus1.req_addr = 32'h8000_0004; bus1.req_wdata = 32'hCAFE_F00D;
        bus1.req_wmask = 8'h0F; bus1.req_valid = 1'b1;
        check("lat1_ready", 32'(bus1.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        check("lat1_rsp_early", 32'(bus1.rsp_valid), 32'd0);
        @(negedge clk);
        check("lat1_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
        check("lat1_err", 32'(bus1.rsp_err), 32'd0);
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        check("lat1_idle", 32'(bus1.req_ready), 32'd1);

        // 6: misaligned load
        access(1'b0, 32'h8000_0012, 32'd0, 8'h00, rd, er, lat, rdy);
`ifdef YSYX_24100005_DMEM_ALIGN_CHECK_EN
        check("mis_ld_err", 32'(er), 32'd1);
        check("mis_ld_rdata", rd, 32'd0);
`else
        check("mis_ld_err", 32'(er), 32'd0);
        check("mis_ld_rdata", rd, 32'hDE22_BE44);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
